// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with optional
// hardwired zero register, per-entry pending scoreboard and a sequential
// bulk-clear engine (one entry per cycle).
// Build option: define REGFILE_MP_BYPASS_EN to forward an accepted write
// to any read port addressing the same entry in the same cycle.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam bit          ZR    = (ZERO_REG != 0);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic                wr_ok;
  logic                last_clr;
  logic [ADDR_W-1:0]   ra;

  // A write is accepted only when idle and not aimed at the zero register.
  assign wr_ok    = wr_en && (state_q == IDLE) && !(ZR && (wr_addr == '0));
  assign last_clr = (state_q == CLEAR) && (cnt_q == '1);

  // Clear FSM state and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM next-state and status outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (last_clr) begin
          clr_done = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage: clear engine owns the array while running, else the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state: write clears, then clear engine, then mark sets
  // (a newer producer outranks a completing write, but not the clear slot).
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) pend_d[wr_addr] = 1'b0;
    if (state_q == CLEAR) pend_d[cnt_q] = 1'b0;
    if (mark_en && !((state_q == CLEAR) && (mark_addr == cnt_q)))
      pend_d[mark_addr] = 1'b1;
    if (ZR) pend_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Combinational read ports with optional same-cycle write forwarding.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    ra      = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      if (ZR && (ra == '0)) rd_data[i*DATA_W +: DATA_W] = '0;
      else                  rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
      rd_pend[i] = pend_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_ok && (wr_addr == ra)) begin
        rd_data[i*DATA_W +: DATA_W] = wr_data;
        rd_pend[i] = mark_en && (mark_addr == ra);
      end
`endif
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the pipelined MIPS core; the successor to the fixed 32x32, 2-read-port register file.
- Adds a configurable read-port count, hardwired zero register, per-entry pending scoreboard for hazard detection, and a sequential bulk-clear engine.
- Sits between the decode stage (reads, scoreboard marks) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as zero, ignores writes and is never pending; 0 = entry 0 is ordinary

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
rd_pend  out  NUM_RD  pending-bit of the entry addressed by each read port
mark_en  in  1  set pending bit for mark_addr (decode issued a producer)
mark_addr  in  ADDR_W  entry to mark pending
clr_req  in  1  request bulk clear of all entries
busy  out  1  high while the clear engine runs
clr_done  out  1  one-cycle pulse on the final clear cycle

Behaviour:
- Reset (rst_n low, asynchronous): all entries 0, all pending bits 0, FSM IDLE, clear counter 0, busy 0, clr_done 0.
- Reads are combinational: rd_data[i] = entry[rd_addr[i]]. With ZERO_REG=1, address 0 returns 0.
- Write: when wr_en=1 in IDLE, entry[wr_addr] <= wr_data at the rising edge. With ZERO_REG=1, writes to address 0 are dropped.
- Scoreboard:
  - mark_en sets pend[mark_addr]; an accepted write clears pend[wr_addr].
  - Same-cycle mark and write to the same address: set wins, because a newer producer is outstanding.
  - rd_pend[i] = pend[rd_addr[i]], combinational.
  - With ZERO_REG=1, pend[0] is held at 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req=1; counter <= 0; busy asserts from the next cycle.
  - In CLEAR, each cycle entry[counter] <= 0 and pend[counter] <= 0, then counter increments. Clearing takes exactly DEPTH cycles.
  - clr_done=1 in the cycle counter==DEPTH-1; the FSM then returns to IDLE and busy drops the following cycle.
  - clr_req while busy is ignored; no restart or queueing.
- Writes during CLEAR are discarded, and the pending bit is not cleared. mark_en during CLEAR is honoured unless mark_addr==counter in that cycle, in which case the clear wins.
- Reads during CLEAR return current storage; already-cleared entries read 0.
- Counter width is ADDR_W. It wraps to 0 only on CLEAR exit and never aliases.
- rst_n asserted mid-clear aborts immediately to the reset state; no clr_done pulse is produced.
- Multiple read ports may address the same entry; each returns identical data.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_en=1, the FSM is IDLE, wr_addr==rd_addr[i], and the address is not the zero register, then rd_data[i]=wr_data in the same cycle. rd_pend[i] reads 0 in that case unless mark_en targets the same address that cycle.
- Undefined: reads return stored contents only; the new value is visible the cycle after the write.

Test Plan:
- Reset then write 0xDEADBEEF to r5, read r5 on port 0 next cycle -> 0xDEADBEEF; port 1 reading r6 -> 0.
- Write 0x12345678 to r0 with ZERO_REG=1 -> r0 reads 0. Repeat with ZERO_REG=0 -> r0 reads 0x12345678.
- mark r7, then write r7 = 0x55 -> rd_pend 1 for one cycle then 0. Same-cycle mark and write on r9 -> r9 pending stays 1.
- Fill r1..r31 with their index, then pulse clr_req:
  - busy high for 32 cycles, clr_done on the last cycle.
  - r3 reads 0 after cycle 4 while r31 still reads 31.
  - A write to r20 issued mid-clear is lost.
- Drop rst_n at cycle 10 of a clear -> all entries 0 immediately, busy 0, no clr_done.
- With REGFILE_MP_BYPASS_EN, write r4 = 0xA5A5A5A5 while reading r4 in the same cycle -> rd_data = 0xA5A5A5A5 that cycle. Without the macro -> the old value that cycle, then 0xA5A5A5A5 the next.
